// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, queries the BTB each cycle, steers the next PC
// (sequential / predicted-taken / backend redirect) and forwards resolved taken branches to the BTB.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] btb_query_pc,
  input  logic [31:0] btb_pred_pc,
  input  logic        btb_pred_valid,
  output logic        btb_update_valid,
  output logic [31:0] btb_update_addr,
  output logic [31:0] btb_update_target,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target
);

  // Handshake: an entry transfers on a rising edge where out_valid & out_ready are both 1.
  // Once out_valid is raised, all out_* stay stable until the transfer, unless a redirect
  // squashes the entry (out_valid drops combinationally in the redirect cycle).

  logic [31:0] s0_pc;
  logic        s1_valid;
  logic [31:0] s1_pc;
  logic        s1_live;
  logic        s1_hold_taken;
  logic [31:0] s1_hold_tgt;

  logic        pred_taken;
  logic [31:0] pred_tgt;
  logic        advance;

  assign btb_query_pc = s0_pc;

  // BTB response belongs to s1_pc only in the cycle right after s1 loads; afterwards use the captured copy.
  assign pred_taken = s1_live ? btb_pred_valid : s1_hold_taken;
  assign pred_tgt   = s1_live ? btb_pred_pc    : s1_hold_tgt;

  assign advance = ~s1_valid | out_ready;

  assign out_valid       = s1_valid & ~redirect_valid;
  assign out_pc          = s1_pc;
  assign out_pred_taken  = pred_taken;
  assign out_pred_target = pred_taken ? pred_tgt : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_pc         <= RESET_PC;
      s1_valid      <= 1'b0;
      s1_pc         <= 32'h0;
      s1_live       <= 1'b0;
      s1_hold_taken <= 1'b0;
      s1_hold_tgt   <= 32'h0;
    end else begin
      if (s1_live) begin
        s1_hold_taken <= btb_pred_valid;
        s1_hold_tgt   <= btb_pred_pc;
      end

      if (redirect_valid) begin
        s0_pc    <= redirect_pc;
        s1_valid <= 1'b0;
        s1_live  <= 1'b0;
      end else if (s1_live && btb_pred_valid) begin
        // The sequential PC sitting in s0 is discarded; this costs one bubble per taken prediction.
        s0_pc    <= btb_pred_pc;
        s1_valid <= s1_valid & ~out_ready;
        s1_live  <= 1'b0;
      end else if (advance) begin
        s1_pc    <= s0_pc;
        s1_valid <= 1'b1;
        s1_live  <= 1'b1;
        s0_pc    <= s0_pc + 32'd4;
      end else begin
        s1_live  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_update_valid  <= 1'b0;
      btb_update_addr   <= 32'h0;
      btb_update_target <= 32'h0;
    end else begin
      btb_update_valid  <= res_valid & res_taken;
      btb_update_addr   <= res_pc;
      btb_update_target <= res_target;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed cycle table, mid-stream reset sequence,
// then randomized traffic checked against a fetch-stream reference model.
module tb_fetch_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] btb_query_pc;
  logic [31:0] btb_pred_pc;
  logic        btb_pred_valid;
  logic        btb_update_valid;
  logic [31:0] btb_update_addr;
  logic [31:0] btb_update_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  fetch_pc_gen #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .btb_query_pc(btb_query_pc), .btb_pred_pc(btb_pred_pc), .btb_pred_valid(btb_pred_valid),
    .btb_update_valid(btb_update_valid), .btb_update_addr(btb_update_addr),
    .btb_update_target(btb_update_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_pc(res_pc), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BTB model: one-cycle lookup table, garbage target on miss ----------------
  logic [31:0] btb_key [4];
  logic [31:0] btb_val [4];
  int          btb_n;

  function automatic logic btb_hit(input logic [31:0] pc);
    for (int i = 0; i < btb_n; i++) if (btb_key[i] == pc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] btb_tgt(input logic [31:0] pc);
    for (int i = 0; i < btb_n; i++) if (btb_key[i] == pc) return btb_val[i];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    btb_pred_valid <= btb_hit(btb_query_pc);
    btb_pred_pc    <= btb_hit(btb_query_pc) ? btb_tgt(btb_query_pc) : $urandom;
  end

  // ---------------- checking ----------------
  int checks;
  int passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        resv;
    logic        rest;
    logic [31:0] respc;
    logic [31:0] restgt;
    logic        ov;
    logic [31:0] opc;
    logic        ot;
    logic [31:0] otg;
    logic        uv;
    logic [31:0] ua;
    logic [31:0] ut;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic resv, input logic rest, input logic [31:0] respc,
                              input logic [31:0] restgt, input logic ov, input logic [31:0] opc,
                              input logic ot, input logic [31:0] otg, input logic uv,
                              input logic [31:0] ua, input logic [31:0] ut);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.resv = resv; v.rest = rest; v.respc = respc;
    v.restgt = restgt; v.ov = ov; v.opc = opc; v.ot = ot; v.otg = otg; v.uv = uv;
    v.ua = ua; v.ut = ut;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic resv, input logic rest, input logic [31:0] respc,
                       input logic [31:0] restgt);
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    res_valid = resv; res_taken = rest; res_pc = respc; res_target = restgt;
  endtask

  // ---------------- random-phase scoreboard state ----------------
  logic [31:0] exp_q [$];
  logic [31:0] exp_pc;
  logic        prev_stall;
  logic [31:0] prev_pc;
  logic        prev_taken;
  logic [31:0] prev_tgt;
  int          accepts;
  logic [63:0] upd_word;

  initial begin
    checks = 0; passes = 0; accepts = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    btb_n = 1; btb_key[0] = 32'h8; btb_val[0] = 32'h100;

    //           rdy  rv   rpc            resv rest respc  restgt  ov   opc            ot   otg     uv   ua     ut
    vecs[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[1]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[2]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h4,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[3]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h8,          1, 32'h100, 0, 32'h0,  32'h0);
    vecs[4]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[5]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h100,        0, 32'h0,   0, 32'h0,  32'h0);
    vecs[6]  = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h104,        0, 32'h0,   0, 32'h0,  32'h0);
    vecs[7]  = mk(1, 1, 32'h8,          0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[8]  = mk(0, 0, 32'h0,          0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[9]  = mk(0, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h8,          1, 32'h100, 0, 32'h0,  32'h0);
    vecs[10] = mk(0, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h8,          1, 32'h100, 0, 32'h0,  32'h0);
    vecs[11] = mk(0, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h8,          1, 32'h100, 0, 32'h0,  32'h0);
    vecs[12] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h8,          1, 32'h100, 0, 32'h0,  32'h0);
    vecs[13] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h100,        0, 32'h0,   0, 32'h0,  32'h0);
    vecs[14] = mk(0, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h104,        0, 32'h0,   0, 32'h0,  32'h0);
    vecs[15] = mk(0, 1, 32'h200,        1, 1, 32'h40, 32'h80, 0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[16] = mk(1, 0, 32'h0,          1, 0, 32'h44, 32'h88, 0, 32'h0,          0, 32'h0,   1, 32'h40, 32'h80);
    vecs[17] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h200,        0, 32'h0,   0, 32'h0,  32'h0);
    vecs[18] = mk(1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[19] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  0, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);
    vecs[20] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'hFFFF_FFFC,  0, 32'h0,   0, 32'h0,  32'h0);
    vecs[21] = mk(1, 0, 32'h0,          0, 0, 32'h0,  32'h0,  1, 32'h0,          0, 32'h0,   0, 32'h0,  32'h0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_query_pc", btb_query_pc, RESET_PC);
    chk("rst_upd_valid", {31'h0, btb_update_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].resv, vecs[i].rest,
            vecs[i].respc, vecs[i].restgt);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ov});
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].opc);
        chk($sformatf("v%0d_pred_taken", i), {31'h0, out_pred_taken}, {31'h0, vecs[i].ot});
        chk($sformatf("v%0d_pred_target", i), out_pred_target, vecs[i].otg);
      end
      chk($sformatf("v%0d_upd_valid", i), {31'h0, btb_update_valid}, {31'h0, vecs[i].uv});
      if (vecs[i].uv) begin
        chk($sformatf("v%0d_upd_addr", i), btb_update_addr, vecs[i].ua);
        chk($sformatf("v%0d_upd_target", i), btb_update_target, vecs[i].ut);
      end
      @(negedge clk);
    end

    // ---- pending update then reset asserted mid-stream ----
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h123, 32'h456);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mid_upd_valid", {31'h0, btb_update_valid}, 32'h1);
    chk("mid_upd_addr", btb_update_addr, 32'h123);
    chk("mid_out_valid_pre", {31'h0, out_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_upd_valid", {31'h0, btb_update_valid}, 32'h0);
    chk("mid_rst_query_pc", btb_query_pc, RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_out_valid0", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("restart_out_valid1", {31'h0, out_valid}, 32'h1);
    chk("restart_out_pc", out_pc, RESET_PC);

    // ---- randomized traffic against the fetch-stream model ----
    rst = 1'b0;
    btb_n = 4;
    for (int i = 0; i < 4; i++) begin
      btb_key[i] = 32'($urandom_range(0, 15)) * 32'd4;
      btb_val[i] = 32'($urandom_range(0, 31)) * 32'd4;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC;
    prev_stall = 1'b0;
    prev_pc = 32'h0; prev_taken = 1'b0; prev_tgt = 32'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 31)) * 32'd4,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      #1;
      if (btb_update_valid) begin
        if (exp_q.size() == 0) chk("rnd_upd_unexpected", 32'h1, 32'h0);
        else begin
          upd_word = {exp_q.pop_front(), exp_q.pop_front()};
          chk("rnd_upd_addr", btb_update_addr, upd_word[63:32]);
          chk("rnd_upd_target", btb_update_target, upd_word[31:0]);
        end
      end else if (exp_q.size() != 0) begin
        chk("rnd_upd_missing", 32'h0, 32'h1);
        exp_q.delete();
      end
      if (res_valid && res_taken) begin
        exp_q.push_back(res_pc);
        exp_q.push_back(res_target);
      end

      if (redirect_valid) begin
        chk("rnd_squash", {31'h0, out_valid}, 32'h0);
      end else begin
        if (prev_stall) begin
          chk("rnd_hold_valid", {31'h0, out_valid}, 32'h1);
          chk("rnd_hold_pc", out_pc, prev_pc);
          chk("rnd_hold_taken", {31'h0, out_pred_taken}, {31'h0, prev_taken});
          chk("rnd_hold_tgt", out_pred_target, prev_tgt);
        end
        if (out_valid && out_ready) begin
          accepts++;
          chk("rnd_acc_pc", out_pc, exp_pc);
          chk("rnd_acc_taken", {31'h0, out_pred_taken}, {31'h0, btb_hit(exp_pc)});
          chk("rnd_acc_tgt", out_pred_target, btb_tgt(exp_pc));
          exp_pc = btb_hit(exp_pc) ? btb_tgt(exp_pc) : exp_pc + 32'd4;
        end
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_stall = out_valid && !out_ready;
      prev_pc = out_pc; prev_taken = out_pred_taken; prev_tgt = out_pred_target;
      @(negedge clk);
    end
    checks++;
    if (accepts >= 300) passes++;
    else $display("FAIL rnd_throughput: got %0d accepted entries, expected at least 300", accepts);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
